// File: rtl/rx_os_detector_if.sv
// Symbol-stream bundle between the 8b/10b decoder, the ordered-set detector
// and the descrambler stage.
interface rx_os_detector_if;
  logic       in_valid;
  logic [7:0] data_in;
  logic       is_kcode_in;
  logic       decode_err;
  logic       out_valid;
  logic [7:0] data_out;
  logic       is_kcode_out;
  logic       ts_os_flag;
  logic       ts1_det;
  logic       ts2_det;
  logic       skp_os_det;
  logic       eios_det;
  logic [3:0] ts_cnt;
  logic       ts_err;

  modport slave (
    input  in_valid, data_in, is_kcode_in, decode_err,
    output out_valid, data_out, is_kcode_out, ts_os_flag,
           ts1_det, ts2_det, skp_os_det, eios_det, ts_cnt, ts_err
  );

  modport master (
    output in_valid, data_in, is_kcode_in, decode_err,
    input  out_valid, data_out, is_kcode_out, ts_os_flag,
           ts1_det, ts2_det, skp_os_det, eios_det, ts_cnt, ts_err
  );
endinterface

// File: rtl/rx_os_detector.sv
// Ordered-set classifier with a LAT-symbol delay line that tags TS1/TS2 bodies.
// Define OSDET_TS_CHECK_EN to also check TS body symbols idx 7..15 (ts_err).
module rx_os_detector #(
  parameter int LAT = 7
) (
  input  logic            clk,
  input  logic            rst,
  rx_os_detector_if.slave bus
);
  localparam int FW       = $clog2(LAT + 1);
  localparam int HDR_MARK = 6;

  typedef enum logic [2:0] {IDLE, OS_HDR, TS_BODY, SKP_RUN, EIOS_RUN} state_e;
  typedef struct packed {
    logic       flag;
    logic       k;
    logic [7:0] data;
  } sym_t;

  sym_t [LAT-1:0] dl_q;
  logic [FW-1:0]  fill_q;
  logic           out_valid_q;
  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d, nidx;
  logic [3:0]     ts_cnt_q, ts_cnt_d;
  logic [1:0]     ts_type_q, ts_type_d;
  logic           ts1_q, ts1_d, ts2_q, ts2_d, skp_q, skp_d, eios_q, eios_d;
  logic           decide, in_flag;
  logic           is_com, is_skp, is_eie, is_ts1, is_ts2;
`ifdef OSDET_TS_CHECK_EN
  logic [7:0]     ident_q, ident_d;
  logic           ts_err_q, ts_err_d;
`endif

  assign is_com = bus.is_kcode_in  && (bus.data_in == 8'hBC);
  assign is_skp = bus.is_kcode_in  && (bus.data_in == 8'h1C);
  assign is_eie = bus.is_kcode_in  && (bus.data_in == 8'h7C);
  assign is_ts1 = !bus.is_kcode_in && (bus.data_in == 8'h4A);
  assign is_ts2 = !bus.is_kcode_in && (bus.data_in == 8'h45);
  assign nidx   = idx_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ts_cnt_d  = ts_cnt_q;
    ts_type_d = ts_type_q;
    ts1_d     = 1'b0;
    ts2_d     = 1'b0;
    skp_d     = 1'b0;
    eios_d    = 1'b0;
    decide    = 1'b0;
    in_flag   = 1'b0;
`ifdef OSDET_TS_CHECK_EN
    ident_d   = ident_q;
    ts_err_d  = 1'b0;
`endif
    if (bus.in_valid) begin
      if (bus.decode_err) ts_cnt_d = '0;
      // Once a TS is decided its body keeps flagging through errors.
      if (bus.decode_err && state_q != TS_BODY) begin
        state_d = IDLE;
      end else if (is_com) begin
        state_d = OS_HDR;
        idx_d   = '0;
      end else begin
        idx_d = nidx;
        unique case (state_q)
          OS_HDR: begin
            if (nidx == 4'd1 && is_skp) begin
              state_d = SKP_RUN;
              skp_d   = 1'b1;
            end else if (nidx == 4'd1 && is_eie) begin
              state_d = EIOS_RUN;
            end else if (nidx == 4'd6) begin
              if (is_ts1 || is_ts2) begin
                state_d   = TS_BODY;
                decide    = 1'b1;
                in_flag   = 1'b1;
                ts1_d     = is_ts1;
                ts2_d     = is_ts2;
                ts_type_d = is_ts1 ? 2'd1 : 2'd2;
                if (ts_type_d != ts_type_q) ts_cnt_d = 4'd1;
                else if (ts_cnt_q != 4'hF)  ts_cnt_d = ts_cnt_q + 4'd1;
`ifdef OSDET_TS_CHECK_EN
                ident_d   = bus.data_in;
`endif
              end else begin
                state_d  = IDLE;
                ts_cnt_d = '0;
              end
            end
          end
          TS_BODY: begin
            in_flag = 1'b1;
`ifdef OSDET_TS_CHECK_EN
            if (bus.is_kcode_in || bus.data_in != ident_q) begin
              ts_err_d = 1'b1;
              ts_cnt_d = '0;
            end
`endif
            if (nidx == 4'd15) state_d = IDLE;
          end
          SKP_RUN: if (!is_skp) state_d = IDLE;
          EIOS_RUN: begin
            if (!is_eie) begin
              state_d = IDLE;
            end else if (nidx == 4'd3) begin
              eios_d   = 1'b1;
              ts_cnt_d = '0;
              state_d  = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_q        <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      idx_q       <= '0;
      ts_cnt_q    <= '0;
      ts_type_q   <= '0;
      ts1_q       <= 1'b0;
      ts2_q       <= 1'b0;
      skp_q       <= 1'b0;
      eios_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ts_cnt_q    <= ts_cnt_d;
      ts_type_q   <= ts_type_d;
      ts1_q       <= ts1_d;
      ts2_q       <= ts2_d;
      skp_q       <= skp_d;
      eios_q      <= eios_d;
      out_valid_q <= bus.in_valid && (fill_q >= FW'(LAT - 1));
      if (bus.in_valid) begin
        if (fill_q != FW'(LAT)) fill_q <= fill_q + 1'b1;
        dl_q[0] <= {in_flag, bus.is_kcode_in, bus.data_in};
        // At the idx6 decision, stages 1..5 hold idx5..idx1 of the same OS.
        for (int i = 1; i < LAT; i++)
          dl_q[i] <= {dl_q[i-1].flag | (decide && i < HDR_MARK), dl_q[i-1].k, dl_q[i-1].data};
      end
    end
  end

`ifdef OSDET_TS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ident_q  <= '0;
      ts_err_q <= 1'b0;
    end else begin
      ident_q  <= ident_d;
      ts_err_q <= ts_err_d;
    end
  end
  assign bus.ts_err = ts_err_q;
`else
  assign bus.ts_err = 1'b0;
`endif

  assign bus.out_valid    = out_valid_q;
  assign bus.data_out     = dl_q[LAT-1].data;
  assign bus.is_kcode_out = dl_q[LAT-1].k;
  assign bus.ts_os_flag   = dl_q[LAT-1].flag;
  assign bus.ts1_det      = ts1_q;
  assign bus.ts2_det      = ts2_q;
  assign bus.skp_os_det   = skp_q;
  assign bus.eios_det     = eios_q;
  assign bus.ts_cnt       = ts_cnt_q;
endmodule

// File: tb/tb_rx_os_detector.sv
// Self-checking bench: stream-level reference model plus directed and random OS traffic.
module tb_rx_os_detector;
  localparam int LAT    = 7;
  localparam int K_HDR  = 0;
  localparam int K_TS1  = 1;
  localparam int K_TS2  = 2;
  localparam int K_SKP  = 3;
  localparam int K_EIOS = 4;

  logic clk, rst;
  rx_os_detector_if bus();
  rx_os_detector #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  // Reference model: whole accepted stream kept in queues; flags written
  // back onto stream positions once an OS is classified.
  logic [7:0] sq_d[$];
  bit         sq_k[$];
  bit         sq_f[$];
  bit         live;
  int         kind, com_pos, ts_type, m_cnt, p, pos, t;
  logic [7:0] md;
  bit         mk, me;
  bit         exp_ov, exp_k, exp_f, exp_ts1, exp_ts2, exp_skp, exp_eios, exp_err;
  logic [7:0] exp_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_d.delete(); sq_k.delete(); sq_f.delete();
      live = 0; kind = K_HDR; com_pos = 0; ts_type = 0; m_cnt = 0;
      exp_ov = 0; exp_data = 8'h00; exp_k = 0; exp_f = 0;
      exp_ts1 = 0; exp_ts2 = 0; exp_skp = 0; exp_eios = 0; exp_err = 0;
    end else begin
      exp_ov = 0; exp_ts1 = 0; exp_ts2 = 0; exp_skp = 0; exp_eios = 0; exp_err = 0;
      if (bus.in_valid) begin
        md = bus.data_in; mk = bus.is_kcode_in; me = bus.decode_err;
        p = sq_d.size();
        sq_d.push_back(md); sq_k.push_back(mk); sq_f.push_back(1'b0);
        pos = p - com_pos;
        if (me) m_cnt = 0;
        if (me && !(live && (kind == K_TS1 || kind == K_TS2))) begin
          live = 0;
        end else if (mk && md == 8'hBC) begin
          live = 1; com_pos = p; kind = K_HDR;
        end else if (live) begin
          if (kind == K_HDR) begin
            if (pos == 1 && mk && md == 8'h1C) begin
              kind = K_SKP; exp_skp = 1;
            end else if (pos == 1 && mk && md == 8'h7C) begin
              kind = K_EIOS;
            end else if (pos == 6) begin
              t = (!mk && md == 8'h4A) ? 1 : (!mk && md == 8'h45) ? 2 : 0;
              if (t == 0) begin
                live = 0; m_cnt = 0;
              end else begin
                kind = (t == 1) ? K_TS1 : K_TS2;
                for (int q = p - 5; q <= p; q++) sq_f[q] = 1'b1;
                m_cnt = (t == ts_type) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
                ts_type = t;
                exp_ts1 = (t == 1); exp_ts2 = (t == 2);
              end
            end
          end else if (kind == K_TS1 || kind == K_TS2) begin
            sq_f[p] = 1'b1;
`ifdef OSDET_TS_CHECK_EN
            if (mk || md != ((kind == K_TS1) ? 8'h4A : 8'h45)) begin
              exp_err = 1; m_cnt = 0;
            end
`endif
            if (pos == 15) live = 0;
          end else if (kind == K_SKP) begin
            if (!(mk && md == 8'h1C)) live = 0;
          end else begin
            if (!(mk && md == 8'h7C)) live = 0;
            else if (pos == 3) begin
              exp_eios = 1; m_cnt = 0; live = 0;
            end
          end
        end
        if (sq_d.size() >= LAT) begin
          exp_ov   = 1;
          exp_data = sq_d[sq_d.size() - LAT];
          exp_k    = sq_k[sq_k.size() - LAT];
          exp_f    = sq_f[sq_f.size() - LAT];
        end
      end
    end
  end

  int n_ts1 = 0, n_ts2 = 0, n_skp = 0, n_eios = 0, n_err = 0, n_flag = 0;

  always @(negedge clk) begin
    chk("out_valid", int'(bus.out_valid), int'(exp_ov));
    if (exp_ov) begin
      chk("data_out", int'(bus.data_out), int'(exp_data));
      chk("is_kcode_out", int'(bus.is_kcode_out), int'(exp_k));
      chk("ts_os_flag", int'(bus.ts_os_flag), int'(exp_f));
    end
    chk("ts1_det", int'(bus.ts1_det), int'(exp_ts1));
    chk("ts2_det", int'(bus.ts2_det), int'(exp_ts2));
    chk("skp_os_det", int'(bus.skp_os_det), int'(exp_skp));
    chk("eios_det", int'(bus.eios_det), int'(exp_eios));
    chk("ts_err", int'(bus.ts_err), int'(exp_err));
    chk("ts_cnt", int'(bus.ts_cnt), m_cnt);
    if (bus.ts1_det)    n_ts1++;
    if (bus.ts2_det)    n_ts2++;
    if (bus.skp_os_det) n_skp++;
    if (bus.eios_det)   n_eios++;
    if (bus.ts_err)     n_err++;
    if (bus.out_valid && bus.ts_os_flag) n_flag++;
  end

  bit gap_en = 0;

  task automatic sym(input logic [7:0] d, input bit k, input bit e);
    bus.in_valid = 1'b1; bus.data_in = d; bus.is_kcode_in = k; bus.decode_err = e;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.data_in = 8'($urandom);
    bus.is_kcode_in = 1'($urandom); bus.decode_err = 1'($urandom);
    if (gap_en) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_ts(input logic [7:0] id, input int len, input int err_at, input int bad_at);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      case (i)
        0:       d = 8'hBC;
        1, 2:    d = 8'hF7;
        3:       d = 8'h0F;
        4:       d = 8'h02;
        5:       d = 8'h00;
        default: d = id;
      endcase
      if (i == bad_at) d = 8'h4B;
      sym(d, i < 3, i == err_at);
    end
  endtask

  task automatic flush();
    repeat (LAT) sym(8'h00, 1'b0, 1'b0);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int s1, s2, sf, sx;

  initial begin
    clk = 1'b0; rst = 1'b0;
    bus.in_valid = 1'b0; bus.data_in = 8'h00; bus.is_kcode_in = 1'b0; bus.decode_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_ts_cnt", int'(bus.ts_cnt), 0);
    chk("rst_flag", int'(bus.ts_os_flag), 0);

    repeat (6) sym(8'h00, 1'b0, 1'b0);
    chk("fill6_out_valid", int'(bus.out_valid), 0);
    sym(8'h00, 1'b0, 1'b0);
    chk("fill7_out_valid", int'(bus.out_valid), 1);
    chk("fill7_data", int'(bus.data_out), 0);

    s1 = n_ts1; sf = n_flag;
    send_ts(8'h4A, 16, -1, -1);
    chk("ts1_cnt", int'(bus.ts_cnt), 1);
    chk("model_ts1_cnt", m_cnt, 1);
    flush();
    chk("ts1_pulses", n_ts1 - s1, 1);
    chk("ts1_flags", n_flag - sf, 15);

    s2 = n_ts2; sf = n_flag;
    repeat (8) send_ts(8'h45, 16, -1, -1);
    chk("ts2x8_cnt", int'(bus.ts_cnt), 8);
    chk("model_ts2x8_cnt", m_cnt, 8);
    flush();
    chk("ts2x8_pulses", n_ts2 - s2, 8);
    chk("ts2x8_flags", n_flag - sf, 120);
    send_ts(8'h4A, 16, -1, -1);
    chk("ts_type_change_cnt", int'(bus.ts_cnt), 1);
    flush();

    sx = n_skp; sf = n_flag;
    sym(8'hBC, 1'b1, 1'b0);
    repeat (3) sym(8'h1C, 1'b1, 1'b0);
    sym(8'h55, 1'b0, 1'b0);
    flush();
    chk("skp_pulses", n_skp - sx, 1);
    chk("skp_cnt_kept", int'(bus.ts_cnt), 1);
    chk("skp_flags", n_flag - sf, 0);

    sx = n_eios;
    sym(8'hBC, 1'b1, 1'b0);
    repeat (3) sym(8'h7C, 1'b1, 1'b0);
    flush();
    chk("eios_pulses", n_eios - sx, 1);
    chk("eios_cnt", int'(bus.ts_cnt), 0);

    send_ts(8'h45, 16, -1, -1);
    flush();
    s1 = n_ts1; sf = n_flag;
    send_ts(8'h4A, 16, 3, -1);
    flush();
    chk("err_ts_pulses", n_ts1 - s1, 0);
    chk("err_ts_flags", n_flag - sf, 0);
    chk("err_ts_cnt", int'(bus.ts_cnt), 0);

    repeat (17) send_ts(8'h4A, 16, -1, -1);
    chk("sat_cnt", int'(bus.ts_cnt), 15);
    chk("model_sat_cnt", m_cnt, 15);
    flush();

    sx = n_err; sf = n_flag;
    send_ts(8'h4A, 16, -1, 10);
    flush();
`ifdef OSDET_TS_CHECK_EN
    chk("bad_sym_err", n_err - sx, 1);
    chk("bad_sym_cnt", int'(bus.ts_cnt), 0);
`else
    chk("bad_sym_err", n_err - sx, 0);
    chk("bad_sym_cnt", int'(bus.ts_cnt), 15);
`endif
    chk("bad_sym_flags", n_flag - sf, 15);

    s1 = n_ts1; s2 = n_ts2; sf = n_flag;
    send_ts(8'h4A, 10, -1, -1);
    send_ts(8'h45, 16, -1, -1);
    flush();
    chk("trunc_flags", n_flag - sf, 24);
    chk("trunc_ts1", n_ts1 - s1, 1);
    chk("trunc_ts2", n_ts2 - s2, 1);
    chk("trunc_cnt", int'(bus.ts_cnt), 1);

    send_ts(8'h4A, 8, -1, -1);
    do_reset();
    chk("midrst_cnt", int'(bus.ts_cnt), 0);
    repeat (6) sym(8'h11, 1'b0, 1'b0);
    chk("midrst_fill6", int'(bus.out_valid), 0);
    sym(8'h22, 1'b0, 1'b0);
    chk("midrst_fill7", int'(bus.out_valid), 1);
    chk("midrst_data", int'(bus.data_out), 8'h11);

    gap_en = 1;
    for (int it = 0; it < 300; it++) begin
      int r, n;
      logic [7:0] d;
      bit k;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: send_ts(($urandom_range(0, 1) == 0) ? 8'h4A : 8'h45,
                         ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 16,
                         ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : -1,
                         ($urandom_range(0, 4) == 0) ? $urandom_range(7, 15) : -1);
        3: begin
          sym(8'hBC, 1'b1, 1'b0);
          repeat ($urandom_range(1, 5)) sym(8'h1C, 1'b1, 1'b0);
          sym(8'($urandom), 1'b0, 1'b0);
        end
        4: begin
          sym(8'hBC, 1'b1, 1'b0);
          n = $urandom_range(1, 3);
          repeat (n) sym(8'h7C, 1'b1, 1'b0);
          if (n < 3) sym(8'($urandom), 1'($urandom), 1'b0);
        end
        5, 6, 8: begin
          repeat ($urandom_range(1, 8)) begin
            k = (r != 8) && ($urandom_range(0, 2) == 0);
            d = 8'($urandom);
            if (k && $urandom_range(0, 1) == 0) d = 8'hBC;
            sym(d, k, !k && $urandom_range(0, 9) == 0);
          end
        end
        7: repeat ($urandom_range(2, 4)) send_ts(8'h45, 16, -1, -1);
        default: begin
          if ($urandom_range(0, 7) == 0) do_reset();
          else send_ts(8'h4A, 16, -1, -1);
        end
      endcase
    end
    gap_en = 0;
    flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_os_detector.md
RX_OS_DETECTOR -- requirements
Module: rx_os_detector

Interface
REQ-001 The block SHALL have parameter LAT, default 7, meaning the delay-line depth in accepted symbols, fixed at 7.
REQ-002 clk  input  1  symbol clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  decoded symbol present this cycle.
REQ-005 data_in  input  8  decoded symbol from 8b/10b decoder.
REQ-006 is_kcode_in  input  1  symbol is a K-code.
REQ-007 decode_err  input  1  code or disparity error on this symbol.
REQ-008 out_valid  output  1  data_out valid; feeds the descrambler stage.
REQ-009 data_out  output  8  delayed symbol.
REQ-010 is_kcode_out  output  1  delayed K flag.
REQ-011 ts_os_flag  output  1  symbol belongs to a TS1/TS2 body; drives the descrambler data_in_TS_OS input.
REQ-012 ts1_det, ts2_det, skp_os_det, eios_det  output  1 each  single-cycle detection pulses.
REQ-013 ts_cnt  output  4  consecutive identical-TS count.
REQ-014 ts_err  output  1  TS body symbol mismatch pulse.

Function
REQ-015 Delay line of LAT stages SHALL shift only when in_valid=1; data_out, is_kcode_out and ts_os_flag come from the last stage.
REQ-016 out_valid SHALL equal in_valid once LAT symbols have been accepted since reset, else 0; latency is exactly LAT accepted symbols.
REQ-017 Input classifier FSM states: IDLE, OS_HDR, TS_BODY, SKP_RUN, EIOS_RUN; symbol index idx counts 0 (COM) to 15.
REQ-018 Any accepted K28.5 (8'hBC, K) in any state SHALL go to OS_HDR with idx=0; COM restarts a partial OS.
REQ-019 OS_HDR, idx=1: K28.0 (8'h1C, K) -> SKP_RUN with skp_os_det pulse; K28.3 (8'h7C, K) -> EIOS_RUN; other -> stay OS_HDR.
REQ-020 OS_HDR, idx=6: D10.2 (8'h4A, D) -> TS_BODY with ts1_det; D5.2 (8'h45, D) -> TS_BODY with ts2_det; other -> IDLE, no flag.
REQ-021 Detection pulses SHALL assert the cycle after the deciding symbol is accepted (input-relative timing).
REQ-022 On TS1/TS2 decision, ts_os_flag SHALL be 1 on outputs idx 1..15 of that OS; COM output flag 0; symbols outside a TS OS flag 0.
REQ-023 TS_BODY returns to IDLE after idx=15; SKP_RUN returns to IDLE on first non-SKP symbol (1-5 SKPs accepted).
REQ-024 EIOS_RUN: K28.3 at idx 2 and 3 -> eios_det pulse and IDLE; any other symbol -> IDLE without pulse.
REQ-025 decode_err before the idx=6 decision SHALL abort to IDLE with no flag; after the decision, flagging of the current OS continues.
REQ-026 ts_cnt: +1 when decided TS type equals previous type, set to 1 on type change, saturate at 15.
REQ-027 ts_cnt SHALL clear on decode_err, on EIOS, or on an OS aborted before decision; SKP OS leaves it unchanged.
REQ-028 COM arriving during TS_BODY SHALL truncate flagging: outputs after the new COM take the new OS classification.

Reset
REQ-029 rst low SHALL force: delay line all zero, out_valid 0, data_out 8'h00, is_kcode_out 0, ts_os_flag 0, all pulses 0, ts_cnt 0, ts_err 0, FSM IDLE, fill count 0.
REQ-030 Reset mid-OS SHALL discard all buffered symbols; after release LAT new symbols are required before out_valid.

Configuration
REQ-031 With OSDET_TS_CHECK_EN defined, TS_BODY SHALL compare idx 7..15 against the identifier; mismatch pulses ts_err and clears ts_cnt, flagging continues.
REQ-032 Without OSDET_TS_CHECK_EN, only idx 6 is checked and ts_err is tied 0.

Verification
REQ-033 Reset then 7 D-symbols 8'h00 -> out_valid rises on the 7th accepted-symbol edge; data_out 8'h00.
REQ-034 TS1 (BC K, F7 K x2, 8'h0F,02,00, 4A x10) -> ts1_det once; ts_os_flag 0 at COM, 1 for next 15 outputs; ts_cnt 1.
REQ-035 Eight back-to-back TS2 (identifier 45) -> ts2_det x8, ts_cnt 8; then one TS1 -> ts_cnt 1.
REQ-036 BC K, 1C K x3, then 8'h55 D -> skp_os_det one pulse, ts_os_flag 0 throughout, ts_cnt unchanged.
REQ-037 BC K, 7C K x3 -> eios_det pulse, ts_cnt 0; decode_err at idx 3 of a TS -> no flag, IDLE.
REQ-038 With OSDET_TS_CHECK_EN, TS1 with idx 10 = 8'h4B -> ts_err pulse, ts_cnt 0, flag still 1 on idx 1..15.
